// File: rtl/rice_stream_decoder_pkg.sv
// Shared types and widths for the Rice residual stream decoder.
package rice_stream_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNARY  = 2'd1,
        ST_BINARY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int BUF_W   = 32;
    localparam int WORD_W  = 16;
    localparam int RES_W   = 16;
    localparam int U_W     = 17;
    localparam int CNT_W   = 6;
    localparam int SHIFT_W = 4;

    localparam logic [BUF_W-1:0] U_MAX = 32'h0001_FFFF;

    // Zigzag unfold: even u -> u/2, odd u -> -(u+1)/2.
    function automatic logic [RES_W-1:0] zigzag_unfold(input logic [U_W-1:0] u);
        return u[U_W-1:1] ^ {RES_W{u[0]}};
    endfunction

endpackage

// File: rtl/rice_bit_buffer.sv
// Left-aligned 32-bit shift buffer: consume n bits from the top while a new
// word lands directly below the bits that remain.
module rice_bit_buffer
    import rice_stream_decoder_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic [SHIFT_W-1:0] consume_i,
    output logic [WORD_W-1:0]  head_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [BUF_W-1:0] bits_q, bits_d, kept;
    logic [CNT_W-1:0] count_q, count_d, remain;

    // Bits below count are always zero, so the new word can simply be OR-ed in.
    always_comb begin
        kept    = bits_q << consume_i;
        remain  = count_q - CNT_W'(consume_i);
        bits_d  = kept;
        count_d = remain;
        if (clear_i) begin
            bits_d  = '0;
            count_d = '0;
        end else if (load_i) begin
            bits_d  = kept | ({word_i, {(BUF_W-WORD_W){1'b0}}} >> remain);
            count_d = remain + CNT_W'(WORD_W);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bits_q  <= '0;
            count_q <= '0;
        end else begin
            bits_q  <= bits_d;
            count_q <= count_d;
        end
    end

    assign head_o  = bits_q[BUF_W-1 -: WORD_W];
    assign count_o = count_q;

endmodule

// File: rtl/rice_stream_decoder.sv
// Rice residual decoder: unary quotient + k-bit remainder -> zigzag-unfolded
// signed 16-bit residuals, one block of SAMPLES per iStart.
//
// state     | meaning
// ST_IDLE   | waiting for iStart
// ST_UNARY  | counting quotient zeros up to the terminating one
// ST_BINARY | waiting for k remainder bits, then emit
// ST_DONE   | pulse oDone, drop leftover padding bits
module rice_stream_decoder
    import rice_stream_decoder_pkg::*;
#(
    parameter int SAMPLES = 4096,
    parameter int QMAX    = 255
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [3:0]        iK,
    input  logic [WORD_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [RES_W-1:0]  oResidual,
    output logic              oValid,
    output logic              oDone,
    output logic              oError
);

    localparam int Q_W = $clog2(QMAX + 1);
    localparam int S_W = $clog2(SAMPLES + 1);

    state_e             state_q;
    logic [3:0]         k_q;
    logic [Q_W-1:0]     quot_q;
    logic [S_W-1:0]     sample_q;
    logic [RES_W-1:0]   res_q;
    logic               valid_q, done_q, error_q;

    logic [WORD_W-1:0]  head;
    logic [CNT_W-1:0]   count;
    logic               active, has_bit, has_bin, emit, buf_clear, buf_load;
    logic [SHIFT_W-1:0] consume_n;
    logic [WORD_W-1:0]  bin_r;
    logic [BUF_W-1:0]   emit_u;

    always_comb begin
        active    = (state_q == ST_UNARY) || (state_q == ST_BINARY);
        has_bit   = (count != '0);
        has_bin   = (count >= CNT_W'(k_q));
        bin_r     = head >> (5'(WORD_W) - {1'b0, k_q});
        emit_u    = (BUF_W'(quot_q) << k_q) |
                    ((state_q == ST_BINARY) ? BUF_W'(bin_r) : '0);
        emit      = ((state_q == ST_UNARY) && has_bit && head[WORD_W-1] && (k_q == 4'd0)) ||
                    ((state_q == ST_BINARY) && has_bin);
        consume_n = '0;
        if ((state_q == ST_UNARY) && has_bit)
            consume_n = SHIFT_W'(1);
        else if ((state_q == ST_BINARY) && has_bin)
            consume_n = k_q;
        oReady    = active && (count <= CNT_W'(WORD_W));
        buf_load  = iValid && oReady;
        buf_clear = ((state_q == ST_IDLE) && iStart) || (state_q == ST_DONE);
    end

    rice_bit_buffer u_buf (
        .clk_i     (iClock),
        .rst_i     (iReset),
        .clear_i   (buf_clear),
        .load_i    (buf_load),
        .word_i    (iData),
        .consume_i (consume_n),
        .head_o    (head),
        .count_o   (count)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            quot_q   <= '0;
            sample_q <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        k_q      <= iK;
                        quot_q   <= '0;
                        sample_q <= '0;
                        error_q  <= 1'b0;
                        state_q  <= ST_UNARY;
                    end
                end
                ST_UNARY: begin
                    if (has_bit && !head[WORD_W-1]) begin
                        if (quot_q == Q_W'(QMAX)) begin
                            error_q <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            quot_q <= quot_q + Q_W'(1);
                        end
                    end else if (has_bit && (k_q != 4'd0)) begin
                        state_q <= ST_BINARY;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: ;
            endcase

            // Emit overrides the per-state transitions above.
            if (emit) begin
                quot_q <= '0;
                if (emit_u > U_MAX) begin
                    error_q <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    res_q    <= zigzag_unfold(emit_u[U_W-1:0]);
                    valid_q  <= 1'b1;
                    sample_q <= sample_q + S_W'(1);
                    state_q  <= (sample_q == S_W'(SAMPLES - 1)) ? ST_DONE : ST_UNARY;
                end
            end
        end
    end

    assign oResidual = res_q;
    assign oValid    = valid_q;
    assign oDone     = done_q;
    assign oError    = error_q;

endmodule

// File: tb/tb_rice_stream_decoder.sv
// Randomized bench: encodes residuals with a plain Rice/zigzag model, feeds the
// packed words, and compares each decoded residual and block status.
module tb_rice_stream_decoder;

    localparam int SAMPLES = 4;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iStart = 1'b0;
    logic [3:0]  iK     = '0;
    logic [15:0] iData  = '0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [15:0] oResidual;
    logic        oValid, oDone, oError;

    rice_stream_decoder #(.SAMPLES(SAMPLES), .QMAX(255)) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iStart    (iStart),
        .iK        (iK),
        .iData     (iData),
        .iValid    (iValid),
        .oReady    (oReady),
        .oResidual (oResidual),
        .oValid    (oValid),
        .oDone     (oDone),
        .oError    (oError)
    );

    always #5 iClock = ~iClock;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          bitstream[$];
    logic [15:0] words[$];
    logic [15:0] exp_res[$];
    int          blk_first_v;
    int          blk_max_iv;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference encoder: q zeros, a one, then k bits of r; expected value is the
    // arithmetic zigzag inverse of u = q*2^k + r.
    task automatic add_res(input int k, input int q, input int r);
        int u, e;
        for (int i = 0; i < q; i++) bitstream.push_back(1'b0);
        bitstream.push_back(1'b1);
        for (int i = k - 1; i >= 0; i--) bitstream.push_back(bit'((r >> i) & 1));
        u = q * (1 << k) + r;
        e = (u % 2 == 0) ? u / 2 : -((u + 1) / 2);
        exp_res.push_back(16'(e));
    endtask

    task automatic pack_words();
        logic [15:0] w;
        while (bitstream.size() > 0) begin
            w = '0;
            for (int i = 0; i < 16; i++) begin
                w = w << 1;
                if (bitstream.size() > 0) w[0] = bitstream.pop_front();
            end
            words.push_back(w);
        end
    endtask

    task automatic run_block(input logic [3:0] k, input bit gaps, input bit exp_err, input string tag);
        int wi = 0, gap_left = 0, first_v = -1, last_v = -1, max_iv = 0;
        bit done_seen = 1'b0;
        @(negedge iClock);
        iStart = 1'b1;
        iK     = k;
        @(negedge iClock);
        iStart = 1'b0;
        for (int it = 0; it < 4000 && !done_seen; it++) begin
            if (it > 0) @(negedge iClock);
            if (oValid) begin
                if (exp_res.size() == 0) check_eq({tag, " extra oValid"}, 32'd1, 32'd0);
                else check_eq({tag, " residual"}, oResidual, exp_res.pop_front());
                if (first_v < 0) first_v = it;
                if (last_v >= 0 && it - last_v > max_iv) max_iv = it - last_v;
                last_v = it;
            end
            if (oDone) begin
                done_seen = 1'b1;
                if (!exp_err) check_eq({tag, " done lag"}, it - last_v, 1);
            end
            if (gap_left > 0) gap_left--;
            else if (gaps && $urandom_range(0, 5) == 0) gap_left = 10;
            if (!done_seen && gap_left == 0 && wi < words.size()) begin
                iValid = 1'b1;
                iData  = words[wi];
                if (oReady) wi++;
            end else begin
                iValid = 1'b0;
            end
        end
        iValid = 1'b0;
        check_eq({tag, " done seen"}, done_seen, 1'b1);
        check_eq({tag, " missing residuals"}, exp_res.size(), 0);
        check_eq({tag, " oError"}, oError, exp_err);
        exp_res.delete();
        words.delete();
        bitstream.delete();
        blk_first_v = first_v;
        blk_max_iv  = max_iv;
    endtask

    initial begin
        int k, q, r, qlim;

        repeat (3) @(negedge iClock);
        check_eq("reset oReady", oReady, 1'b0);
        check_eq("reset oValid", oValid, 1'b0);
        check_eq("reset oDone", oDone, 1'b0);
        check_eq("reset oError", oError, 1'b0);
        check_eq("reset oResidual", oResidual, 16'h0000);
        iReset = 1'b0;

        // k=2 word 0x9718 -> 0, -1, 1, 5
        words.push_back(16'h9718);
        exp_res.push_back(16'h0000);
        exp_res.push_back(16'hFFFF);
        exp_res.push_back(16'h0001);
        exp_res.push_back(16'h0005);
        run_block(4'd2, 1'b0, 1'b0, "w9718");

        // Asynchronous reset while counting unary zeros
        @(negedge iClock);
        iStart = 1'b1;
        iK     = 4'd3;
        @(negedge iClock);
        iStart = 1'b0;
        iValid = 1'b1;
        iData  = 16'h0000;
        @(negedge iClock);
        iValid = 1'b0;
        repeat (4) @(negedge iClock);
        #2 iReset = 1'b1;
        #1;
        check_eq("async rst oReady", oReady, 1'b0);
        check_eq("async rst oResidual", oResidual, 16'h0000);
        check_eq("async rst oValid", oValid, 1'b0);
        check_eq("async rst oError", oError, 1'b0);
        @(negedge iClock);
        iReset = 1'b0;

        // k=0, four one-bit codes: single-cycle UNARY per residual
        words.push_back(16'hF000);
        repeat (4) exp_res.push_back(16'h0000);
        run_block(4'd0, 1'b0, 1'b0, "k0");
        check_eq("k0 first latency", blk_first_v, 2);
        check_eq("k0 valid spacing", blk_max_iv, 1);

        // Largest legal quotient
        add_res(0, 255, 0);
        add_res(0, 0, 0);
        add_res(0, 3, 0);
        add_res(0, 0, 0);
        pack_words();
        run_block(4'd0, 1'b0, 1'b0, "qmax");

        // 256 zeros -> quotient error, no residuals
        repeat (17) words.push_back(16'h0000);
        run_block(4'd5, 1'b0, 1'b1, "qerr");

        // k=15, q=4 -> u = 0x20000 overflows
        words.push_back(16'h0800);
        words.push_back(16'h0000);
        run_block(4'd15, 1'b0, 1'b1, "uovf");

        // Random blocks over every k, some with 10-cycle input gaps
        for (int blk = 0; blk < 1024; blk++) begin
            k = blk % 16;
            qlim = 17'h1FFFF >> k;
            for (int s = 0; s < SAMPLES; s++) begin
                q = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 4);
                if (q > qlim) q = qlim;
                r = (k == 0) ? 0 : int'($urandom_range(0, (1 << k) - 1));
                add_res(k, q, r);
            end
            pack_words();
            run_block(4'(k), (blk % 4) == 0, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
